// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types and constants for hazard and mul/div logic
package pipe_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam int MD_LATENCY_DEF = 32;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  // $0 is hardwired, so a source naming it can never depend on a writer.
  function automatic logic reads_reg(input logic [REG_W-1:0] src,
                                     input logic             uses,
                                     input logic [REG_W-1:0] dst);
    return uses && (src != REG_ZERO) && (src == dst);
  endfunction
endpackage

// File: rtl/md_busy_timer.sv
// rtl/md_busy_timer.sv - busy timer for the multi-cycle mul/div unit
module md_busy_timer
  import pipe_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_accept,
  output logic md_busy,
  output logic md_done
);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      md_done <= 1'b0;
    end else begin
      md_done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start_accept) begin
            state <= MD_BUSY;
            cnt   <= CNT_W'(MD_LATENCY - 1);
          end
        end
        MD_BUSY: begin
          // Result becomes valid in the first IDLE cycle after the count expires.
          if (cnt == '0) begin
            state   <= MD_IDLE;
            md_done <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign md_busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - stall/flush generator for load-use, branch and mul/div hazards
// HAZARD_STATS_EN adds saturating per-cause stall cycle counters.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic             uses_rs_d,
  input  logic             uses_rt_d,
  input  logic             branch_d,
  input  logic             md_start_d,
  input  logic             md_read_d,
  input  logic [REG_W-1:0] write_reg_e,
  input  logic             reg_write_e,
  input  logic             mem_to_reg_e,
  input  logic [REG_W-1:0] write_reg_m,
  input  logic             mem_to_reg_m,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_e,
  output logic             md_busy,
  output logic             md_done
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_cnt_lw,
  output logic [31:0]      stall_cnt_br,
  output logic [31:0]      stall_cnt_md
`endif
);

  logic use_rs;
  logic use_rt;
  logic dep_e;
  logic dep_m;
  logic lw_stall;
  logic br_stall;
  logic md_stall;
  logic stall;

  // A branch compares both operands in D, so it reads both regardless of uses_*.
  assign use_rs = uses_rs_d | branch_d;
  assign use_rt = uses_rt_d | branch_d;

  assign dep_e = reads_reg(rs_d, use_rs, write_reg_e) | reads_reg(rt_d, use_rt, write_reg_e);
  assign dep_m = reads_reg(rs_d, use_rs, write_reg_m) | reads_reg(rt_d, use_rt, write_reg_m);

  assign lw_stall = rst_n & mem_to_reg_e & reg_write_e & dep_e;
  assign br_stall = rst_n & branch_d & ((reg_write_e & dep_e) | (mem_to_reg_m & dep_m));
  assign md_stall = rst_n & (md_start_d | md_read_d) & md_busy;

  assign stall   = lw_stall | br_stall | md_stall;
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;

  md_busy_timer #(
    .MD_LATENCY(MD_LATENCY),
    .CNT_W     (CNT_W)
  ) u_md_busy_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_accept(md_start_d & ~stall),
    .md_busy     (md_busy),
    .md_done     (md_done)
  );

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_lw <= '0;
      stall_cnt_br <= '0;
      stall_cnt_md <= '0;
    end else begin
      if (lw_stall && stall_cnt_lw != '1) stall_cnt_lw <= stall_cnt_lw + 32'd1;
      if (br_stall && stall_cnt_br != '1) stall_cnt_br <= stall_cnt_br + 32'd1;
      if (md_stall && stall_cnt_md != '1) stall_cnt_md <= stall_cnt_md + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed bench for hazard_scoreboard
module tb_hazard_scoreboard;
  localparam int LAT = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, write_reg_e, write_reg_m;
  logic       uses_rs_d, uses_rt_d, branch_d, md_start_d, md_read_d;
  logic       reg_write_e, mem_to_reg_e, mem_to_reg_m;
  logic       stall_f, stall_d, flush_e, md_busy, md_done;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_lw, stall_cnt_br, stall_cnt_md;
  int          n_lw, n_br, n_md;
`endif

  int checks = 0;
  int errors = 0;
  int md_rem;
  bit md_done_m;

  always #5 clk = ~clk;

  hazard_scoreboard #(.MD_LATENCY(LAT), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d),
    .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d), .branch_d(branch_d),
    .md_start_d(md_start_d), .md_read_d(md_read_d),
    .write_reg_e(write_reg_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
    .write_reg_m(write_reg_m), .mem_to_reg_m(mem_to_reg_m),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_STATS_EN
    , .stall_cnt_lw(stall_cnt_lw), .stall_cnt_br(stall_cnt_br), .stall_cnt_md(stall_cnt_md)
`endif
  );

  // Reference model: does the decode instruction read register r?
  function automatic bit d_reads(input logic [4:0] r);
    bit a, b;
    a = (uses_rs_d || branch_d) && rs_d == r;
    b = (uses_rt_d || branch_d) && rt_d == r;
    return (r != 0) && (a || b);
  endfunction

  function automatic bit m_lw();
    return rst_n && mem_to_reg_e && reg_write_e && d_reads(write_reg_e);
  endfunction

  function automatic bit m_br();
    return rst_n && branch_d &&
           ((reg_write_e && d_reads(write_reg_e)) || (mem_to_reg_m && d_reads(write_reg_m)));
  endfunction

  function automatic bit m_md();
    return rst_n && (md_start_d || md_read_d) && (md_rem > 0);
  endfunction

  function automatic bit m_stall();
    return m_lw() || m_br() || m_md();
  endfunction

  task automatic clear_inputs();
    rs_d = 0; rt_d = 0; write_reg_e = 0; write_reg_m = 0;
    uses_rs_d = 0; uses_rt_d = 0; branch_d = 0; md_start_d = 0; md_read_d = 0;
    reg_write_e = 0; mem_to_reg_e = 0; mem_to_reg_m = 0;
  endtask

  // Advance one clock and move the model: md_rem counts remaining busy cycles.
  task automatic tick();
    bit acc;
    acc = rst_n && md_start_d && !m_stall();
`ifdef HAZARD_STATS_EN
    if (rst_n) begin
      n_lw += int'(m_lw()); n_br += int'(m_br()); n_md += int'(m_md());
    end
`endif
    @(posedge clk);
    if (!rst_n) begin
      md_rem = 0; md_done_m = 0;
`ifdef HAZARD_STATS_EN
      n_lw = 0; n_br = 0; n_md = 0;
`endif
    end else if (md_rem > 0) begin
      md_rem--;
      md_done_m = (md_rem == 0);
    end else begin
      md_done_m = 0;
      if (acc) md_rem = LAT;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 8; rs_d = 8; uses_rs_d = 1; md_start_d = 1;
    #2;
    tick(); tick();
    checks++;
    if ({stall_f, stall_d, flush_e, md_busy, md_done} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got=%b want=00000", {stall_f, stall_d, flush_e, md_busy, md_done});
    end
    clear_inputs();
    rst_n = 1;
    tick();
    checks++;
    if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got=%b want=0", md_busy); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 8; rs_d = 8; uses_rs_d = 1;
    #1;
    checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b111) begin
      errors++; $display("FAIL load_use_stall got=%b want=111", {stall_f, stall_d, flush_e});
    end
    tick();
    mem_to_reg_e = 0; reg_write_e = 0; write_reg_e = 0; mem_to_reg_m = 1; write_reg_m = 8;
    #1;
    checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b000) begin
      errors++; $display("FAIL load_use_release got=%b want=000", {stall_f, stall_d, flush_e});
    end
    tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    reg_write_e = 1; write_reg_e = 5; branch_d = 1; rs_d = 5; rt_d = 6;
    #1;
    checks++;
    if (stall_d !== 1'b1) begin errors++; $display("FAIL branch_e_dep got=%b want=1", stall_d); end
    tick();
    reg_write_e = 0; write_reg_e = 0; mem_to_reg_m = 1; write_reg_m = 6;
    #1;
    checks++;
    if (flush_e !== 1'b1) begin errors++; $display("FAIL branch_m_load got=%b want=1", flush_e); end
    tick();
    mem_to_reg_m = 0;
    #1;
    checks++;
    if (stall_f !== 1'b0) begin errors++; $display("FAIL branch_clear got=%b want=0", stall_f); end
    tick();
  endtask

  task automatic test_zero();
    clear_inputs();
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 0; rs_d = 0; rt_d = 0; uses_rs_d = 1; uses_rt_d = 1;
    #1;
    checks++;
    if (stall_d !== 1'b0) begin errors++; $display("FAIL zero_reg got=%b want=0", stall_d); end
    write_reg_e = 9; rs_d = 9; uses_rs_d = 0; uses_rt_d = 0;
    #1;
    checks++;
    if (stall_d !== 1'b0) begin errors++; $display("FAIL unused_rs got=%b want=0", stall_d); end
    rt_d = 9; uses_rt_d = 1;
    #1;
    checks++;
    if (stall_d !== 1'b1) begin errors++; $display("FAIL used_rt got=%b want=1", stall_d); end
    tick();
    clear_inputs();
  endtask

  task automatic test_md_timing();
    clear_inputs();
    md_start_d = 1;
    #1;
    checks++;
    if (stall_d !== 1'b0) begin errors++; $display("FAIL md_start_free got=%b want=0", stall_d); end
    tick();
    md_start_d = 0; md_read_d = 1;
    for (int c = 1; c <= LAT; c++) begin
      md_start_d = (c == 5);
      #1;
      checks++;
      if (md_busy !== 1'b1 || stall_d !== 1'b1 || md_done !== 1'b0) begin
        errors++;
        $display("FAIL md_busy_cycle%0d got busy=%b stall=%b done=%b want 1 1 0", c, md_busy, stall_d, md_done);
      end
      tick();
    end
    md_start_d = 0;
    #1;
    checks++;
    if (md_done !== 1'b1 || md_busy !== 1'b0 || stall_d !== 1'b0) begin
      errors++; $display("FAIL md_done_cycle got done=%b busy=%b stall=%b want 1 0 0", md_done, md_busy, stall_d);
    end
    md_read_d = 0;
    tick();
    checks++;
    if (md_done !== 1'b0) begin errors++; $display("FAIL md_done_pulse got=%b want=0", md_done); end
  endtask

  task automatic test_blocked_start();
    bit seen_done;
    clear_inputs();
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 8; rs_d = 8; uses_rs_d = 1; md_start_d = 1;
    tick();
    checks++;
    if (md_busy !== 1'b0) begin errors++; $display("FAIL blocked_start_busy got=%b want=0", md_busy); end
    mem_to_reg_e = 0; reg_write_e = 0;
    tick();
    md_start_d = 0;
    checks++;
    if (md_busy !== 1'b1) begin errors++; $display("FAIL retried_start_busy got=%b want=1", md_busy); end
    seen_done = 0;
    for (int i = 0; i < LAT + 4 && !seen_done; i++) begin
      tick();
      seen_done = md_done;
    end
    checks++;
    if (!seen_done) begin errors++; $display("FAIL blocked_start_done got=0 want=1 within bound"); end
    tick();
  endtask

  task automatic test_reset_mid();
    int bad;
    clear_inputs();
    md_start_d = 1;
    tick();
    md_start_d = 0; md_read_d = 1;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (md_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b want=1", md_busy); end
    rst_n = 0;
    md_rem = 0; md_done_m = 0;
`ifdef HAZARD_STATS_EN
    n_lw = 0; n_br = 0; n_md = 0;
`endif
    #1;
    checks++;
    if (md_busy !== 1'b0 || stall_d !== 1'b0) begin
      errors++; $display("FAIL mid_reset got busy=%b stall=%b want 0 0", md_busy, stall_d);
    end
    tick();
    rst_n = 1; md_read_d = 0;
    bad = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      if (md_done !== 1'b0 || md_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mid_reset_no_done got=%0d bad cycles want=0", bad); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      write_reg_e = 5'($urandom_range(0, 3)); write_reg_m = 5'($urandom_range(0, 3));
      uses_rs_d = 1'($urandom); uses_rt_d = 1'($urandom);
      branch_d = ($urandom_range(0, 3) == 0);
      reg_write_e = 1'($urandom); mem_to_reg_e = ($urandom_range(0, 2) == 0);
      mem_to_reg_m = ($urandom_range(0, 2) == 0);
      md_start_d = ($urandom_range(0, 7) == 0);
      md_read_d = ($urandom_range(0, 3) == 0);
      #1;
      checks++;
      if ({stall_f, stall_d, flush_e} !== {3{m_stall()}} || md_busy !== (md_rem > 0) || md_done !== md_done_m) begin
        errors++;
        $display("FAIL random_cycle%0d got stall=%b%b%b busy=%b done=%b want stall=%b busy=%b done=%b",
                 i, stall_f, stall_d, flush_e, md_busy, md_done, m_stall(), md_rem > 0, md_done_m);
      end
      tick();
    end
    clear_inputs();
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    #1;
    checks++;
    if (stall_cnt_lw !== 32'(n_lw) || stall_cnt_br !== 32'(n_br) || stall_cnt_md !== 32'(n_md)) begin
      errors++;
      $display("FAIL stats got %0d %0d %0d want %0d %0d %0d",
               stall_cnt_lw, stall_cnt_br, stall_cnt_md, n_lw, n_br, n_md);
    end
  endtask
`endif

  initial begin
    md_rem = 0; md_done_m = 0;
`ifdef HAZARD_STATS_EN
    n_lw = 0; n_br = 0; n_md = 0;
`endif
    test_reset();
    test_load_use();
    test_branch();
    test_zero();
    test_md_timing();
    test_blocked_start();
    test_reset_mid();
    test_random();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Stall/flush generator paired with data_forward. data_forward resolves hazards by forwarding; this block covers the hazards forwarding cannot fix.
- Freezes F/D and bubbles E on three conditions:
  - load-use;
  - decode-stage branch dependencies;
  - reads or new starts while the multi-cycle mul/div unit is busy.
- Owns the sequential busy timer for the mul/div unit.

Parameters:
- MD_LATENCY, 32, cycles the mul/div unit is busy after an accepted start (legal range 1..63).
- CNT_W, 6, width of the busy counter; must satisfy 2**CNT_W > MD_LATENCY.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- rs_d  in  5  decode source register A
- rt_d  in  5  decode source register B
- uses_rs_d  in  1  decode instruction reads rs
- uses_rt_d  in  1  decode instruction reads rt
- branch_d  in  1  decode instruction is a branch compared in D
- md_start_d  in  1  decode instruction starts mul/div
- md_read_d  in  1  decode instruction reads HI/LO (mfhi/mflo)
- write_reg_e  in  5  E-stage destination
- reg_write_e  in  1  E-stage writes register
- mem_to_reg_e  in  1  E-stage is load
- write_reg_m  in  5  M-stage destination
- mem_to_reg_m  in  1  M-stage is load
- stall_f  out  1  hold PC
- stall_d  out  1  hold F/D register
- flush_e  out  1  clear D/E register (insert bubble)
- md_busy  out  1  mul/div unit busy
- md_done  out  1  one-cycle pulse when the result becomes valid

Behaviour:
- Register $0 never causes a hazard. Every comparison requires the register to be non-zero and the matching uses_* bit set. branch_d implies both uses_* bits.
- lw_stall = mem_to_reg_e & reg_write_e & (rs_d==write_reg_e | rt_d==write_reg_e).
- br_stall = branch_d & either of:
  - reg_write_e & write_reg_e in {rs_d, rt_d};
  - mem_to_reg_m & write_reg_m in {rs_d, rt_d}.
- md_stall = (md_start_d | md_read_d) & md_busy.
- stall_f = stall_d = flush_e = lw_stall | br_stall | md_stall. These outputs are combinational, same cycle, with no registered latency.
- Mul/div FSM states: IDLE, BUSY.
  - IDLE to BUSY: on a clock edge with md_start_d=1 and stall_d=0. cnt loads MD_LATENCY-1.
  - In BUSY: cnt decrements each cycle. When cnt==0, next state is IDLE and md_done pulses high for that IDLE cycle.
  - md_busy = (state==BUSY).
- Start is accepted only when stall_d=0. A start blocked by lw/br stall is retried by the held instruction; no start is lost or duplicated.
- md_start_d or md_read_d during the last BUSY cycle (cnt==0) still stalls. It proceeds on the following cycle, which coincides with the md_done pulse.
- MD_LATENCY=1: BUSY lasts exactly one cycle.
- Reset, asynchronous and including mid-operation: state=IDLE, cnt=0, md_done=0. All outputs are 0 while rst_n=0.
- No md_start_d is accepted in the same cycle rst_n deasserts unless the edge samples rst_n=1.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds three 32-bit output ports: stall_cnt_lw, stall_cnt_br, stall_cnt_md.
  - Each counts cycles in which its cause is asserted.
  - Counts are independent: overlapping causes increment every asserted counter.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - REG_W=5;
  - REG_ZERO=5'd0;
  - md_state_t enum {MD_IDLE, MD_BUSY};
  - default MD_LATENCY constant, shared with the mul/div datapath.
- One sub-module, md_busy_timer, containing the FSM, counter, md_busy and md_done. Its inputs are start_accept, clk and rst_n.
- Hazard comparisons stay in the top level.

Test Plan:
- Load-use: E=lw to $8; D=add reading $8 (uses_rs_d=1) -> stall_f=stall_d=flush_e=1 for exactly 1 cycle. Next cycle, with the load in M, no stall.
- Branch dependencies:
  - E=add writing $5, D=beq $5,$6 -> stall 1 cycle.
  - Then M=lw $6 and the same beq -> stall 1 more cycle.
- $0 immunity: E=lw to $0, D reads $0 -> no stall.
  - Same setup with uses_rs_d=0 and rs_d equal to the load destination -> no stall.
- Mul/div timing: MD_LATENCY=32; md_start_d at cycle 0 with no other stall.
  - md_busy is high for cycles 1..32.
  - md_read_d held from cycle 1 -> stall through cycle 32.
  - md_done is high and stall is low at cycle 33.
  - A second md_start_d at cycle 5 also stalls.
- Blocked start and reset:
  - md_start_d coincident with lw_stall -> md_busy stays 0 that cycle, rises the cycle after the start is unstalled.
  - rst_n pulsed low at cycle 10 of BUSY -> md_busy=0 and stall_d=0 immediately, with no md_done afterwards.
- With HAZARD_STATS_EN: 3 load-use stalls, 2 branch stalls and one 32-cycle md read stall -> counters read 3, 2, 32.
